// File: rtl/cic_comp_fir.sv
// Decimating droop-compensation FIR behind cic_d: one tap per clock through a single
// multiplier, fixed coefficients, tvalid-qualified output without backpressure.
//
// state  | meaning
// IDLE   | waiting for a trigger sample
// MAC    | tap reads plus two-stage pipeline drain (NUM_TAPS+2 cycles)
// OUT    | output strobe cycle; a trigger here starts the next MAC
module cic_comp_fir #(
  parameter int INP_DW    = 18,
  parameter int OUT_DW    = 18,
  parameter int COEF_DW   = 18,
  parameter int NUM_TAPS  = 15,
  parameter int DECIM     = 2,
  parameter int OUT_SHIFT = 16,
  parameter logic [COEF_DW*NUM_TAPS-1:0] COEFFS =
    ({{(COEF_DW*NUM_TAPS-1){1'b0}}, 1'b1} << (COEF_DW*((NUM_TAPS-1)/2) + COEF_DW-2))
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [INP_DW-1:0] s_axis_in_tdata,
  input  logic              s_axis_in_tvalid,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  output logic              overrun
);

  localparam int AW     = $clog2(NUM_TAPS + 2);
  localparam int D      = 1 << AW;
  localparam int CW     = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PW     = INP_DW + COEF_DW;
  localparam int ACC_DW = PW + $clog2(NUM_TAPS);

  localparam logic [AW-1:0] TAP_LAST = AW'(NUM_TAPS - 1);
  localparam logic [AW-1:0] MAC_LAST = AW'(NUM_TAPS + 1);
  localparam logic [1:0]    PH_LAST  = 2'(DECIM - 1);
  localparam logic signed [ACC_DW-1:0] OUT_MAX =
    {{(ACC_DW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
  localparam logic signed [ACC_DW-1:0] OUT_MIN =
    {{(ACC_DW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                     state_q, state_d;
  logic        [1:0]          phase_q, phase_d;
  logic        [AW-1:0]       wptr_q, wptr_d;
  logic        [AW-1:0]       snap_q, snap_d;
  logic        [AW-1:0]       tap_q, tap_d;
  logic signed [INP_DW-1:0]   dline_q [D];
  logic signed [INP_DW-1:0]   dline_d [D];
  logic signed [INP_DW-1:0]   rd_q, rd_d;
  logic signed [COEF_DW-1:0]  coef_q, coef_d;
  logic signed [PW-1:0]       prod_q, prod_d;
  logic signed [ACC_DW-1:0]   acc_q, acc_d;
  logic        [OUT_DW-1:0]   odata_q, odata_d;
  logic                       ovalid_q, ovalid_d;
  logic                       overrun_q, overrun_d;

  logic signed [COEF_DW-1:0]  coef_arr [1<<CW];
  logic                       trigger;
  logic                       start;
  logic        [AW-1:0]       rd_addr;
  logic signed [ACC_DW-1:0]   acc_sum;
  logic signed [ACC_DW-1:0]   shifted;
  logic        [OUT_DW-1:0]   sat_val;

  always_comb begin
    for (int i = 0; i < (1<<CW); i++) coef_arr[i] = '0;
    for (int i = 0; i < NUM_TAPS; i++) coef_arr[i] = COEFFS[COEF_DW*i +: COEF_DW];
  end

  always_comb begin
    trigger = s_axis_in_tvalid && (phase_q == PH_LAST);

    dline_d = dline_q;
    wptr_d  = wptr_q;
    phase_d = phase_q;
    if (s_axis_in_tvalid) begin
      dline_d[wptr_q] = s_axis_in_tdata;
      wptr_d          = wptr_q + AW'(1);
      phase_d         = trigger ? 2'd0 : phase_q + 2'd1;
    end

    // Taps walk backwards from the snapshot; later writes land ahead of it.
    rd_addr = snap_q - tap_q;
    acc_sum = acc_q + ACC_DW'(prod_q);
    shifted = acc_sum >>> OUT_SHIFT;
    if (shifted > OUT_MAX)      sat_val = OUT_MAX[OUT_DW-1:0];
    else if (shifted < OUT_MIN) sat_val = OUT_MIN[OUT_DW-1:0];
    else                        sat_val = shifted[OUT_DW-1:0];

    state_d   = state_q;
    snap_d    = snap_q;
    tap_d     = tap_q;
    rd_d      = rd_q;
    coef_d    = coef_q;
    prod_d    = prod_q;
    acc_d     = acc_q;
    odata_d   = odata_q;
    ovalid_d  = 1'b0;
    overrun_d = overrun_q;
    start     = 1'b0;

    case (state_q)
      S_MAC: begin
        rd_d   = dline_q[rd_addr];
        coef_d = (tap_q <= TAP_LAST) ? coef_arr[tap_q[CW-1:0]] : '0;
        prod_d = PW'(rd_q) * PW'(coef_q);
        acc_d  = acc_sum;
        if (trigger) overrun_d = 1'b1;
        if (tap_q == MAC_LAST) begin
          state_d  = S_OUT;
          odata_d  = sat_val;
          ovalid_d = 1'b1;
        end else begin
          tap_d = tap_q + AW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        if (trigger) begin
          start   = 1'b1;
          state_d = S_MAC;
          snap_d  = wptr_q;
          tap_d   = '0;
        end
      end
    endcase

    // Zeroed coef/product keep the first two drain cycles from adding stale terms.
    if (start) begin
      coef_d = '0;
      prod_d = '0;
      acc_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      wptr_q    <= '0;
      snap_q    <= '0;
      tap_q     <= '0;
      for (int i = 0; i < D; i++) dline_q[i] <= '0;
      rd_q      <= '0;
      coef_q    <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      odata_q   <= '0;
      ovalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      wptr_q    <= wptr_d;
      snap_q    <= snap_d;
      tap_q     <= tap_d;
      dline_q   <= dline_d;
      rd_q      <= rd_d;
      coef_q    <= coef_d;
      prod_q    <= prod_d;
      acc_q     <= acc_d;
      odata_q   <= odata_d;
      ovalid_q  <= ovalid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_axis_out_tdata  = odata_q;
  assign m_axis_out_tvalid = ovalid_q;
  assign overrun           = overrun_q;

endmodule

// File: doc/cic_comp_fir.md
# cic_comp_fir

Decimating compensation FIR placed directly downstream of `cic_d`; it consumes the CIC output stream and corrects the CIC passband droop. It decimates by `DECIM` using a single time-multiplexed multiplier with one tap per clock and coefficients fixed by parameter. The output is a narrower, rate-reduced `tvalid`-qualified stream with no backpressure, matching the rest of the chain.

## Interface
- `INP_DW`, 18, input sample width (signed); set equal to the upstream `cic_d` `OUT_DW`
- `OUT_DW`, 18, output sample width (signed)
- `COEF_DW`, 18, coefficient width (signed)
- `NUM_TAPS`, 15, number of taps; range 1..64
- `DECIM`, 2, decimation factor; range 1..4
- `OUT_SHIFT`, 16, arithmetic right shift applied to the accumulator before saturation
- `COEFFS`, unit impulse (tap (NUM_TAPS-1)/2 = 2^(COEF_DW-2), all others 0), packed `COEF_DW*NUM_TAPS` vector; c[k] = `COEFFS[COEF_DW*k +: COEF_DW]`
- `clk`, in, 1, single clock, rising edge
- `reset_n`, in, 1, synchronous reset, active low
- `s_axis_in_tdata`, in, INP_DW, signed input sample
- `s_axis_in_tvalid`, in, 1, input sample strobe; no ready signal
- `m_axis_out_tdata`, out, OUT_DW, signed output sample; holds its value between strobes
- `m_axis_out_tvalid`, out, 1, one-cycle output strobe
- `overrun`, out, 1, sticky flag: a trigger was dropped because the MAC was busy

## Operation
- **Delay line:** circular buffer of depth D = 2^clog2(NUM_TAPS+2).
  - Every `s_axis_in_tvalid` writes the sample and advances the write pointer, modulo D.
  - Writes are accepted in every state.
- **Phase counter:** counts accepted samples modulo `DECIM`.
  - A sample is a trigger when phase == DECIM-1, evaluated before the increment.
  - With DECIM=1, every sample is a trigger.
- **Output equation:** y[n] = sum over k=0..NUM_TAPS-1 of c[k]·x[n-k], where x[n] is the trigger sample.
  - Tap addresses are taken relative to the write pointer snapshot captured at the trigger.
  - Up to 2 later writes during the MAC do not corrupt the result.
- **FSM states:**
  - `IDLE`: a trigger causes a transition to `MAC`; the accumulator clears and the snapshot is taken.
  - `MAC`: one tap per cycle for NUM_TAPS cycles, through a registered read and a registered product; then `OUT`.
  - `OUT`: output register is written and the strobe is asserted; returns to `IDLE` in the same cycle.
- **Busy trigger:** a trigger arriving while not in `IDLE` is dropped.
  - The sample is still written and the phase still advances.
  - `overrun` is set to 1 and stays set until reset.
- **Widths:**
  - Product: INP_DW+COEF_DW.
  - Accumulator: ACC_DW = INP_DW+COEF_DW+clog2(NUM_TAPS); it cannot overflow.
- **Output conversion:** output = saturate(acc >>> OUT_SHIFT) to OUT_DW.
  - Arithmetic shift with floor (truncation toward −∞).
  - Clamps to [−2^(OUT_DW−1), 2^(OUT_DW−1)−1].
- **Reset:**
  - Buffer entries, phase, pointer, accumulator and FSM clear (FSM to `IDLE`).
  - `m_axis_out_tdata`=0, `m_axis_out_tvalid`=0, `overrun`=0.
  - A reset asserted mid-MAC aborts the computation; no strobe follows.
- **Start-up:** because the buffer is zero after reset, the first outputs are partial convolutions with zero history.

## Timing
- **Latency:** if the trigger `tvalid` is in cycle t, `m_axis_out_tvalid` is high in cycle t+L, L = NUM_TAPS+3 (t+18 at defaults). The strobe lasts exactly 1 cycle.
- **Trigger acceptance:** the FSM accepts a trigger in cycle t+L, the same cycle as the strobe.
  - Minimum trigger spacing is L cycles.
  - Minimum input spacing is ceil(L/DECIM) cycles.
- **Input gaps:** arbitrary gaps between inputs are allowed; there is no timeout.
- **Reset timing:**
  - `reset_n` low in cycle r: all outputs read reset values from cycle r+1.
  - The first post-reset sample is accepted in the first cycle with `reset_n` high.

## Test plan
- **Passthrough:** defaults, DECIM=1, inputs 1..20 with `tvalid` every 20 cycles.
  - Expect outputs 0,0,0,0,0,0,0,1,2,… (delay (NUM_TAPS−1)/2 = 7 samples).
  - Each strobe at trigger+18.
- **Coefficient readback:** COEFFS = k+1 for k=0..14, OUT_SHIFT=0, DECIM=1, single impulse 1 followed by zeros.
  - Expect outputs 1,2,…,15, then 0.
- **Decimation phase:** DECIM=2 with a ramp input.
  - Expect exactly one strobe per 2 inputs, first strobe after input #2.
  - Expect output count = floor(inputs/2).
- **Saturation:** all coefficients = 2^(COEF_DW−1)−1, input held at max positive, then max negative.
  - Expect output 2^(OUT_DW−1)−1, then −2^(OUT_DW−1).
- **Overrun:** DECIM=1 with input spacing 10 (< L).
  - Every second trigger dropped; `overrun` rises at the first dropped trigger and stays high.
  - Accepted outputs still equal the reference convolution.
- **Reset mid-MAC:** `reset_n` low 5 cycles after a trigger.
  - No strobe follows; all outputs 0.
  - The next trigger after reset produces a result computed from zero history.
